// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter in front of a single-port SRAM. One requester is
// granted per cycle; the accepted command is registered onto the SRAM port,
// and read responses come back tagged with the requester id two cycles
// after acceptance.
module sram_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   input  logic [NUM_REQ-1:0]             i_req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
   output logic [NUM_REQ-1:0]             o_req_ready,
   output logic [NUM_REQ-1:0]             o_rsp_valid,
   output logic [ID_WIDTH-1:0]            o_rsp_id,
   output logic [DATA_WIDTH-1:0]          o_rsp_data,
   output logic [ADDR_WIDTH-1:0]          o_sram_addr,
   output logic                           o_sram_write,
   output logic                           o_sram_read,
   output logic [DATA_WIDTH-1:0]          o_sram_data,
   input  logic [DATA_WIDTH-1:0]          i_sram_data
);

   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   grant_id;
   logic [ID_WIDTH-1:0]   cmd_id;
   logic [NUM_REQ-1:0]    grant;
   logic                  found;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_write;
   int                    idx;

   // Circular search from rr_ptr for the first valid requester.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && i_req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = ID_WIDTH'(idx);
            found      = 1'b1;
         end
      end
   end

   assign o_req_ready = grant;
   assign accept      = found;

   // Select the granted requester's command fields.
   always_comb begin
      sel_addr  = i_req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
      sel_data  = i_req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      sel_write = i_req_write[grant_id];
   end

   // Advance the round-robin pointer past the requester just accepted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
      end
   end

   // Command stage: register the accepted request onto the SRAM port.
   // Address/data hold their last value when idle; only the enables matter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_sram_addr  <= '0;
         o_sram_data  <= '0;
         o_sram_write <= 1'b0;
         o_sram_read  <= 1'b0;
         cmd_id       <= '0;
      end else begin
         o_sram_write <= accept & sel_write;
         o_sram_read  <= accept & ~sel_write;
         if (accept) begin
            o_sram_addr <= sel_addr;
            o_sram_data <= sel_data;
            cmd_id      <= grant_id;
         end
      end
   end

   // Response stage: the SRAM samples a read on the same edge this loads,
   // so the strobe lines up with its registered read data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rsp_valid <= '0;
         o_rsp_id    <= '0;
      end else begin
         o_rsp_valid <= '0;
         if (o_sram_read) begin
            o_rsp_valid[cmd_id] <= 1'b1;
            o_rsp_id            <= cmd_id;
         end
      end
   end

   assign o_rsp_data = i_sram_data;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural single-port SRAM.
// Memory is preloaded with mem[a] = a + 0x40, so expected read data is
// known by address.
`timescale 1ns/1ps
module tb_sram_rr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_WIDTH = 2;
   localparam int ADDR_WIDTH = 6;
   localparam int DATA_WIDTH = 8;

   logic                          clk;
   logic                          rst_n;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [ID_WIDTH-1:0]           rsp_id;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic [ADDR_WIDTH-1:0]         sram_addr;
   logic                          sram_write;
   logic                          sram_read;
   logic [DATA_WIDTH-1:0]         sram_wdata;
   logic [DATA_WIDTH-1:0]         sram_rdata;

   logic [DATA_WIDTH-1:0]         mem [64];

   int n_checks;
   int n_fail;

   sram_rr_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_req_valid(req_valid),
      .i_req_write(req_write),
      .i_req_addr(req_addr),
      .i_req_data(req_data),
      .o_req_ready(req_ready),
      .o_rsp_valid(rsp_valid),
      .o_rsp_id(rsp_id),
      .o_rsp_data(rsp_data),
      .o_sram_addr(sram_addr),
      .o_sram_write(sram_write),
      .o_sram_read(sram_read),
      .o_sram_data(sram_wdata),
      .i_sram_data(sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port SRAM with registered read data.
   always @(posedge clk) begin
      if (sram_write) mem[sram_addr] <= sram_wdata;
      if (sram_read)  sram_rdata <= mem[sram_addr];
   end

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int k, input logic v, input logic w,
                          input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
      req_valid[k] = v;
      req_write[k] = w;
      req_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = a;
      req_data[k*DATA_WIDTH +: DATA_WIDTH] = d;
   endtask

   task automatic idle_all();
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      logic [NUM_REQ-1:0] exp_rdy;
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < NUM_REQ; k++)
         set_req(k, 1'b1, 1'b0, ADDR_WIDTH'(6'h10 + k), 8'h00);
      next_cycle();
      next_cycle();
      #1;
      n_checks++;
      if (sram_write !== 1'b0 || sram_read !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_enables: write=%b read=%b expected 0 0", sram_write, sram_read);
      end
      n_checks++;
      if (rsp_valid !== 4'b0000 || rsp_id !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_rsp: valid=%b id=%0d expected 0000 0", rsp_valid, rsp_id);
      end
      n_checks++;
      if (sram_addr !== 6'h00 || sram_wdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_cmd: addr=%h data=%h expected 00 00", sram_addr, sram_wdata);
      end
      rst_n = 1'b1;
      #1;
      exp_rdy = 4'b0001;
      n_checks++;
      if (req_ready !== exp_rdy) begin
         n_fail++;
         $display("FAIL reset_first_grant: ready=%b expected %b", req_ready, exp_rdy);
      end
      idle_all();
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] exp_rdy;
      logic [ID_WIDTH-1:0] eid;
      idle_all();
      do_reset();
      for (int k = 0; k < NUM_REQ; k++)
         set_req(k, 1'b1, 1'b0, ADDR_WIDTH'(6'h10 + k), 8'h00);
      #1;
      for (int c = 0; c < 10; c++) begin
         exp_rdy = 4'b0001 << (c % 4);
         n_checks++;
         if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rr_grant c=%0d: ready=%b expected %b", c, req_ready, exp_rdy);
         end
         if (c >= 1) begin
            n_checks++;
            if (sram_read !== 1'b1 || sram_addr !== ADDR_WIDTH'(6'h10 + ((c-1) % 4))) begin
               n_fail++;
               $display("FAIL rr_cmd c=%0d: read=%b addr=%h expected 1 %h", c, sram_read,
                        sram_addr, 6'h10 + ((c-1) % 4));
            end
         end
         if (c >= 2) begin
            eid = ID_WIDTH'((c-2) % 4);
            n_checks++;
            if (rsp_valid !== (4'b0001 << eid) || rsp_id !== eid ||
                rsp_data !== DATA_WIDTH'(8'h50 + eid)) begin
               n_fail++;
               $display("FAIL rr_rsp c=%0d: valid=%b id=%0d data=%h expected %b %0d %h", c,
                        rsp_valid, rsp_id, rsp_data, 4'b0001 << eid, eid, 8'h50 + eid);
            end
         end else begin
            n_checks++;
            if (rsp_valid !== 4'b0000) begin
               n_fail++;
               $display("FAIL rr_no_early_rsp c=%0d: valid=%b expected 0000", c, rsp_valid);
            end
         end
         next_cycle();
         #1;
      end
      idle_all();
   endtask

   task automatic test_back_to_back();
      logic [NUM_REQ-1:0] exp_rdy;
      logic [NUM_REQ-1:0] exp_rsp;
      idle_all();
      do_reset();
      for (int c = 0; c < 11; c++) begin
         if (c < 8) set_req(2, 1'b1, 1'b0, ADDR_WIDTH'(6'h20 + c), 8'h00);
         else       set_req(2, 1'b0, 1'b0, 6'h00, 8'h00);
         #1;
         exp_rdy = (c < 8) ? 4'b0100 : 4'b0000;
         n_checks++;
         if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL b2b_ready c=%0d: ready=%b expected %b", c, req_ready, exp_rdy);
         end
         exp_rsp = (c >= 2 && c < 10) ? 4'b0100 : 4'b0000;
         n_checks++;
         if (rsp_valid !== exp_rsp) begin
            n_fail++;
            $display("FAIL b2b_rsp_valid c=%0d: valid=%b expected %b", c, rsp_valid, exp_rsp);
         end
         if (c >= 2 && c < 10) begin
            n_checks++;
            if (rsp_id !== 2'd2 || rsp_data !== DATA_WIDTH'(8'h60 + (c-2))) begin
               n_fail++;
               $display("FAIL b2b_rsp_data c=%0d: id=%0d data=%h expected 2 %h", c, rsp_id,
                        rsp_data, 8'h60 + (c-2));
            end
         end
         next_cycle();
      end
      idle_all();
   endtask

   task automatic test_write_read();
      idle_all();
      do_reset();
      set_req(1, 1'b1, 1'b1, 6'h3F, 8'hA5);
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL wr_grant: ready=%b expected 0010", req_ready);
      end
      next_cycle();
      set_req(1, 1'b0, 1'b0, 6'h00, 8'h00);
      set_req(3, 1'b1, 1'b0, 6'h3F, 8'h00);
      #1;
      n_checks++;
      if (sram_write !== 1'b1 || sram_read !== 1'b0 || sram_addr !== 6'h3F || sram_wdata !== 8'hA5) begin
         n_fail++;
         $display("FAIL wr_cmd: write=%b read=%b addr=%h data=%h expected 1 0 3f a5",
                  sram_write, sram_read, sram_addr, sram_wdata);
      end
      n_checks++;
      if (req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL rd_grant: ready=%b expected 1000", req_ready);
      end
      next_cycle();
      set_req(3, 1'b0, 1'b0, 6'h00, 8'h00);
      #1;
      n_checks++;
      if (sram_read !== 1'b1 || sram_write !== 1'b0 || rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL rd_cmd: read=%b write=%b rsp_valid=%b expected 1 0 0000",
                  sram_read, sram_write, rsp_valid);
      end
      next_cycle();
      #1;
      n_checks++;
      if (rsp_valid !== 4'b1000 || rsp_id !== 2'd3 || rsp_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL wr_rd_rsp: valid=%b id=%0d data=%h expected 1000 3 a5",
                  rsp_valid, rsp_id, rsp_data);
      end
      next_cycle();
      #1;
      n_checks++;
      if (rsp_valid !== 4'b0000 || sram_write !== 1'b0 || sram_read !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_rd_idle: rsp_valid=%b write=%b read=%b expected 0000 0 0",
                  rsp_valid, sram_write, sram_read);
      end
   endtask

   task automatic test_wrap();
      idle_all();
      do_reset();
      set_req(2, 1'b1, 1'b0, 6'h01, 8'h00);
      next_cycle();
      set_req(2, 1'b0, 1'b0, 6'h00, 8'h00);
      set_req(0, 1'b1, 1'b0, 6'h02, 8'h00);
      set_req(3, 1'b1, 1'b0, 6'h03, 8'h00);
      #1;
      n_checks++;
      if (req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL wrap_grant3: ready=%b expected 1000", req_ready);
      end
      next_cycle();
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL wrap_grant0: ready=%b expected 0001", req_ready);
      end
      next_cycle();
      #1;
      n_checks++;
      if (req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL wrap_grant3_again: ready=%b expected 1000", req_ready);
      end
      idle_all();
      next_cycle();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_reset_inflight();
      idle_all();
      do_reset();
      set_req(0, 1'b1, 1'b0, 6'h10, 8'h00);
      next_cycle();
      set_req(1, 1'b1, 1'b0, 6'h11, 8'h00);
      #1;
      n_checks++;
      if (sram_read !== 1'b1 || req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL inflight_pre: read=%b ready=%b expected 1 0010", sram_read, req_ready);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001 || sram_read !== 1'b0) begin
         n_fail++;
         $display("FAIL inflight_rst: ready=%b read=%b expected 0001 0", req_ready, sram_read);
      end
      next_cycle();
      idle_all();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL inflight_dropped c=%0d: rsp_valid=%b expected 0000", c, rsp_valid);
         end
         next_cycle();
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst_n = 1'b0;
      idle_all();
      for (int i = 0; i < 64; i++) mem[i] = DATA_WIDTH'(i + 8'h40);
      test_reset();
      test_round_robin();
      test_back_to_back();
      test_write_read();
      test_wrap();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
